eth_tx_axis_pkt_fifo: RTL and testbench

ETH_TX_AXIS_PKT_FIFO -- requirements
Module: eth_tx_axis_pkt_fifo

---
 rtl/eth_tx_axis_pkt_fifo.sv | 148 ++++++++++++++
 tb/tb_eth_tx_axis_pkt_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO for an Ethernet TX path.
// Packets are committed only on a good tlast; overflowing or sender-flagged packets are dropped.
module eth_tx_axis_pkt_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH_LOG2  = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    s_tlast,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [TUSER_WIDTH-1:0]  s_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic [TUSER_WIDTH-1:0]  m_tuser,
    output logic [DEPTH_LOG2:0]     pkt_count,
    output logic [15:0]             drop_count,
    output logic                    drop_pulse
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int WORD_W = DATA_WIDTH + KEEP_W + TUSER_WIDTH + 1;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic {ST_ACCEPT, ST_DROP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_c_q, wr_c_d;
    logic [PTR_W-1:0]   wr_s_q, wr_s_d;
    logic [PTR_W-1:0]   rd_q;
    logic [PTR_W-1:0]   rd_free;
    logic [PTR_W-1:0]   pkt_count_q;
    logic [15:0]        drop_count_q;
    logic               drop_pulse_q;
    logic               m_tvalid_q;
    logic               ready_q;
    logic               beat, full, wr_en, commit, drop, fetch, out_last;
    logic [WORD_W-1:0]  s_word;
    logic [WORD_W-1:0]  rd_word_q;
    logic [WORD_W-1:0]  mem [DEPTH];

    assign s_word  = {s_tdata, s_tkeep, s_tuser, s_tlast};
    assign beat    = s_tvalid && ready_q;
    // The beat held in the output register still owns its slot until it is transferred.
    assign rd_free = rd_q - PTR_W'(m_tvalid_q);
    assign full    = (wr_s_q - rd_free) == PTR_W'(DEPTH);
    assign fetch   = (wr_c_q != rd_q) && (!m_tvalid_q || m_tready);
    assign out_last = m_tvalid_q && m_tready && rd_word_q[0];

    always_comb begin
        state_d = state_q;
        wr_c_d  = wr_c_q;
        wr_s_d  = wr_s_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                if (beat) begin
                    if (full) begin
                        wr_s_d = wr_c_q;
                        drop   = 1'b1;
                        if (!s_tlast) begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        wr_en  = 1'b1;
                        wr_s_d = wr_s_q + PTR_W'(1);
                        if (s_tlast) begin
                            if (s_tuser[0]) begin
                                wr_s_d = wr_c_q;
                                drop   = 1'b1;
                            end else begin
                                wr_c_d = wr_s_q + PTR_W'(1);
                                commit = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (beat && s_tlast) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_s_q[DEPTH_LOG2-1:0]] <= s_word;
        end
        if (fetch) begin
            rd_word_q <= mem[rd_q[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ACCEPT;
            wr_c_q       <= '0;
            wr_s_q       <= '0;
            rd_q         <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            drop_pulse_q <= 1'b0;
            m_tvalid_q   <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            state_q      <= state_d;
            wr_c_q       <= wr_c_d;
            wr_s_q       <= wr_s_d;
            drop_pulse_q <= drop;
            if (drop && drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            if (fetch) begin
                rd_q       <= rd_q + PTR_W'(1);
                m_tvalid_q <= 1'b1;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
            case ({commit, out_last})
                2'b10:   pkt_count_q <= pkt_count_q + PTR_W'(1);
                2'b01:   pkt_count_q <= pkt_count_q - PTR_W'(1);
                default: pkt_count_q <= pkt_count_q;
            endcase
        end
    end

    assign s_tready   = ready_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = rd_word_q[WORD_W-1 -: DATA_WIDTH];
    assign m_tkeep    = rd_word_q[TUSER_WIDTH+1 +: KEEP_W];
    assign m_tuser    = rd_word_q[1 +: TUSER_WIDTH];
    assign m_tlast    = rd_word_q[0];
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
    assign drop_pulse = drop_pulse_q;
endmodule

// File: tb/tb_eth_tx_axis_pkt_fifo.sv
// Directed bench for eth_tx_axis_pkt_fifo with a 16-beat buffer; output beats are
// collected by a negedge monitor and compared against the beats the bench expects to commit.
module tb_eth_tx_axis_pkt_fifo;
    localparam int DW = 64;
    localparam int DL = 4;

    logic          clk;
    logic          rst;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] s_tdata;
    logic [7:0]    s_tkeep;
    logic [0:0]    s_tuser;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b1;
    logic [DW-1:0] m_tdata;
    logic [7:0]    m_tkeep;
    logic [0:0]    m_tuser;
    logic [DL:0]   pkt_count;
    logic [15:0]   drop_count;
    logic          drop_pulse;

    eth_tx_axis_pkt_fifo #(.DATA_WIDTH(DW), .TUSER_WIDTH(1), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .pkt_count(pkt_count), .drop_count(drop_count), .drop_pulse(drop_pulse)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int drop_seen = 0;
    int stall_err = 0;
    int first_drop_beat = 0;
    bit rnd_ready = 1'b0;
    bit ready_force = 1'b1;
    logic [73:0] exp_q[$];
    logic [73:0] out_q[$];
    int          out_cyc[$];
    logic [73:0] m_word;
    logic [73:0] prev_word;
    logic        prev_stall = 1'b0;

    assign m_word = {m_tdata, m_tkeep, m_tuser, m_tlast};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || m_word !== prev_word)) stall_err <= stall_err + 1;
            prev_stall <= m_tvalid && !m_tready;
            prev_word  <= m_word;
            if (m_tvalid && m_tready) begin
                out_q.push_back(m_word);
                out_cyc.push_back(cyc);
            end
            if (drop_pulse) drop_seen <= drop_seen + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int id, input int len, input bit bad, input bit expect_ok,
                            input int gap_pct);
        logic [7:0] kk;
        logic [73:0] w;
        for (int b = 0; b < len; b++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_tvalid = 1'b0;
                tick();
            end
            kk = 8'hFF;
            s_tvalid = 1'b1;
            s_tlast  = (b == len - 1);
            s_tdata  = {id[31:0], b[31:0]};
            s_tkeep  = s_tlast ? (kk >> (id % 8)) : kk;
            s_tuser  = 1'(s_tlast && bad);
            w = {s_tdata, s_tkeep, s_tuser, s_tlast};
            if (expect_ok) exp_q.push_back(w);
            tick();
            if (drop_pulse && first_drop_beat == 0) first_drop_beat = b + 1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        $display("tx pkt id=%0d len=%0d bad=%0d", id, len, bad);
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic compare_out(input string tag);
        int n;
        check({tag, "_beat_count"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int d0, lat, len, guard;
        rst = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        check("post_rst_s_tready", s_tready, 1);

        // 4-beat good packet, continuous m_tready
        send_pkt(1, 4, 0, 1, 0);
        d0 = cyc;
        check("t1_store_fwd", out_q.size(), 0);
        check("t1_pkt_count_1", pkt_count, 1);
        wait_out(4, 20);
        lat = (out_cyc.size() >= 4) ? out_cyc[0] - d0 : 99;
        check("t1_latency_le2", (lat >= 1 && lat <= 2), 1);
        check("t1_back2back", (out_cyc.size() >= 4) ? out_cyc[3] - out_cyc[0] : 99, 3);
        repeat (3) tick();
        check("t1_pkt_count_0", pkt_count, 0);
        compare_out("t1");

        // 20-beat packet overflows the 16-beat buffer at beat 17
        first_drop_beat = 0;
        d0 = drop_seen;
        send_pkt(2, 20, 0, 0, 0);
        repeat (5) tick();
        check("t2_drop_beat", first_drop_beat, 17);
        check("t2_drop_pulses", drop_seen - d0, 1);
        check("t2_drop_count", drop_count, 1);
        check("t2_no_output", out_q.size(), 0);
        check("t2_pkt_count", pkt_count, 0);
        send_pkt(3, 3, 0, 1, 0);
        wait_out(3, 20);
        compare_out("t2_next");

        // sender-flagged bad packet
        d0 = drop_seen;
        send_pkt(4, 5, 1, 0, 0);
        check("t3_pkt_count", pkt_count, 0);
        repeat (5) tick();
        check("t3_drop_count", drop_count, 2);
        check("t3_drop_pulses", drop_seen - d0, 1);
        check("t3_no_output", out_q.size(), 0);

        // 1-beat packets every cycle
        for (int i = 0; i < 20; i++) send_pkt(10 + i, 1, 0, 1, 0);
        wait_out(20, 40);
        check("t4_drop_count", drop_count, 2);
        compare_out("t4");

        // random stalls, random lengths, sender paced by its own in-flight beat count
        rnd_ready = 1'b1;
        d0 = stall_err;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 8);
            guard = 0;
            while ((exp_q.size() - out_q.size() + len) > 16 && guard < 200) begin
                tick();
                guard++;
            end
            send_pkt(100 + p, len, 0, 1, 20);
        end
        wait_out(exp_q.size(), 3000);
        check("t5_stable_under_stall", stall_err - d0, 0);
        check("t5_drop_count", drop_count, 2);
        compare_out("t5");
        rnd_ready = 1'b0;
        ready_force = 1'b0;
        repeat (2) tick();

        // reset with a stalled output packet and a partial input packet
        send_pkt(50, 3, 0, 0, 0);
        s_tvalid = 1'b1; s_tlast = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_tdata = {32'd51, 32'(b)};
            s_tkeep = 8'hFF;
            tick();
        end
        check("t6_pre_valid", m_tvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_m_tvalid", m_tvalid, 0);
        check("t6_rst_pkt_count", pkt_count, 0);
        check("t6_rst_drop_count", drop_count, 0);
        check("t6_rst_s_tready", s_tready, 0);
        s_tvalid = 1'b0;
        ready_force = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        out_q.delete(); out_cyc.delete(); exp_q.delete();
        tick();
        check("t6_s_tready", s_tready, 1);
        send_pkt(52, 3, 0, 1, 0);
        wait_out(3, 20);
        repeat (4) tick();
        check("t6_pkt_count", pkt_count, 0);
        compare_out("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
